// File: rtl/l2_dary_sdp_arb.sv
// Access controller for one simple-dual-port L2 data-array bank: round-robin
// sharing of the write port (two writers) and read port (two readers), zero-init sweep.
module l2_dary_sdp_arb #(
  parameter int AW      = 9,
  parameter int DW      = 256,
  parameter int SW      = DW / 8,
  parameter bit INIT_EN = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          rd0_req_i,
  input  logic [AW-1:0] rd0_addr_i,
  output logic          rd0_gnt_o,
  input  logic          rd1_req_i,
  input  logic [AW-1:0] rd1_addr_i,
  output logic          rd1_gnt_o,
  output logic          rd_rsp_vld_o,
  output logic          rd_rsp_id_o,
  output logic [DW-1:0] rd_rsp_data_o,
  input  logic          wr0_req_i,
  input  logic [AW-1:0] wr0_addr_i,
  input  logic [DW-1:0] wr0_data_i,
  input  logic [SW-1:0] wr0_strob_i,
  output logic          wr0_gnt_o,
  input  logic          wr1_req_i,
  input  logic [AW-1:0] wr1_addr_i,
  input  logic [DW-1:0] wr1_data_i,
  input  logic [SW-1:0] wr1_strob_i,
  output logic          wr1_gnt_o,
  output logic          init_done_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_waddr_o,
  output logic [DW-1:0] ram_wdata_o,
  output logic [SW-1:0] ram_wdata_strob_o,
  output logic          ram_re_o,
  output logic [AW-1:0] ram_raddr_o,
  input  logic [DW-1:0] ram_rdata_i
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          wr_ptr_reg, wr_ptr_next;
  logic          rd_ptr_reg, rd_ptr_next;
  logic          rsp_vld_reg, rsp_id_reg, fwd_match_reg;
  logic [DW-1:0] fwd_data_reg;
  logic [SW-1:0] fwd_strob_reg;

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    wr_ptr_next       = wr_ptr_reg;
    rd_ptr_next       = rd_ptr_reg;
    wr0_gnt_o         = 1'b0;
    wr1_gnt_o         = 1'b0;
    rd0_gnt_o         = 1'b0;
    rd1_gnt_o         = 1'b0;
    ram_we_o          = 1'b0;
    ram_waddr_o       = '0;
    ram_wdata_o       = '0;
    ram_wdata_strob_o = '0;
    ram_re_o          = 1'b0;
    ram_raddr_o       = '0;
    if (rst_n_i) begin
      case (state_reg)
        ST_INIT: begin
          ram_we_o          = 1'b1;
          ram_waddr_o       = cnt_reg;
          ram_wdata_strob_o = '1;
          cnt_next          = cnt_reg + {{(AW-1){1'b0}}, 1'b1};
          if (cnt_reg == {AW{1'b1}})
            state_next = ST_RUN;
        end
        default: begin
          // Pointer names the port that wins a tie; it flips to the loser after each grant.
          wr0_gnt_o = wr0_req_i & (~wr1_req_i | ~wr_ptr_reg);
          wr1_gnt_o = wr1_req_i & (~wr0_req_i |  wr_ptr_reg);
          rd0_gnt_o = rd0_req_i & (~rd1_req_i | ~rd_ptr_reg);
          rd1_gnt_o = rd1_req_i & (~rd0_req_i |  rd_ptr_reg);
          if (wr0_gnt_o) begin
            ram_we_o          = 1'b1;
            ram_waddr_o       = wr0_addr_i;
            ram_wdata_o       = wr0_data_i;
            ram_wdata_strob_o = wr0_strob_i;
            wr_ptr_next       = 1'b1;
          end else if (wr1_gnt_o) begin
            ram_we_o          = 1'b1;
            ram_waddr_o       = wr1_addr_i;
            ram_wdata_o       = wr1_data_i;
            ram_wdata_strob_o = wr1_strob_i;
            wr_ptr_next       = 1'b0;
          end
          if (rd0_gnt_o) begin
            ram_re_o    = 1'b1;
            ram_raddr_o = rd0_addr_i;
            rd_ptr_next = 1'b1;
          end else if (rd1_gnt_o) begin
            ram_re_o    = 1'b1;
            ram_raddr_o = rd1_addr_i;
            rd_ptr_next = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg     <= INIT_EN ? ST_INIT : ST_RUN;
      cnt_reg       <= '0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      rsp_vld_reg   <= 1'b0;
      rsp_id_reg    <= 1'b0;
      fwd_match_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      rsp_vld_reg   <= ram_re_o;
      if (ram_re_o)
        rsp_id_reg <= rd1_gnt_o;
      fwd_match_reg <= ram_we_o & ram_re_o & (ram_waddr_o == ram_raddr_o);
    end
  end

  // The RAM returns pre-write data on a same-address collision; these hold the write to patch it.
  always_ff @(posedge clk_i) begin
    fwd_data_reg  <= ram_wdata_o;
    fwd_strob_reg <= ram_wdata_strob_o;
  end

  generate
    for (genvar gi = 0; gi < SW; gi++) begin : g_fwd
      assign rd_rsp_data_o[gi*8 +: 8] = (fwd_match_reg && fwd_strob_reg[gi]) ?
                                        fwd_data_reg[gi*8 +: 8] : ram_rdata_i[gi*8 +: 8];
    end
  endgenerate

  assign rd_rsp_vld_o = rsp_vld_reg;
  assign rd_rsp_id_o  = rsp_id_reg;
  assign init_done_o  = (state_reg == ST_RUN);

endmodule

// File: tb/tb_l2_dary_sdp_arb.sv
// Randomized bench for l2_dary_sdp_arb: behavioural RAM, shadow memory and
// arbitration reference model, plus directed reset/init/forwarding scenarios.
module tb_l2_dary_sdp_arb;
  localparam int AW = 9;
  localparam int DW = 256;
  localparam int SW = 32;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_req [2];
  logic [AW-1:0] rd_addr [2];
  logic          rd_gnt [2];
  logic          wr_req [2];
  logic [AW-1:0] wr_addr [2];
  logic [DW-1:0] wr_data [2];
  logic [SW-1:0] wr_strb [2];
  logic          wr_gnt [2];
  logic          rd_rsp_vld, rd_rsp_id, init_done;
  logic [DW-1:0] rd_rsp_data;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [SW-1:0] ram_strb;

  always #5 clk = ~clk;

  l2_dary_sdp_arb #(.AW(AW), .DW(DW), .SW(SW), .INIT_EN(1'b1)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .rd0_req_i(rd_req[0]), .rd0_addr_i(rd_addr[0]), .rd0_gnt_o(rd_gnt[0]),
    .rd1_req_i(rd_req[1]), .rd1_addr_i(rd_addr[1]), .rd1_gnt_o(rd_gnt[1]),
    .rd_rsp_vld_o(rd_rsp_vld), .rd_rsp_id_o(rd_rsp_id), .rd_rsp_data_o(rd_rsp_data),
    .wr0_req_i(wr_req[0]), .wr0_addr_i(wr_addr[0]), .wr0_data_i(wr_data[0]),
    .wr0_strob_i(wr_strb[0]), .wr0_gnt_o(wr_gnt[0]),
    .wr1_req_i(wr_req[1]), .wr1_addr_i(wr_addr[1]), .wr1_data_i(wr_data[1]),
    .wr1_strob_i(wr_strb[1]), .wr1_gnt_o(wr_gnt[1]),
    .init_done_o(init_done),
    .ram_we_o(ram_we), .ram_waddr_o(ram_waddr), .ram_wdata_o(ram_wdata),
    .ram_wdata_strob_o(ram_strb), .ram_re_o(ram_re), .ram_raddr_o(ram_raddr),
    .ram_rdata_i(ram_rdata)
  );

  // Behavioural SDP RAM: read returns the pre-write contents on a collision.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= ram[ram_raddr];
    if (ram_we)
      for (int b = 0; b < SW; b++)
        if (ram_strb[b]) ram[ram_waddr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  typedef struct { bit id; logic [DW-1:0] data; } rsp_t;
  logic [DW-1:0] ref_mem [DEPTH];
  rsp_t          rsp_q [$];
  int            wr_pref, rd_pref, init_left;
  logic          exp_wr_gnt [2];
  logic          exp_rd_gnt [2];
  logic [1:0]    act_wr_gnt, act_rd_gnt;
  logic          last_rsp_vld, last_rsp_id;
  logic [DW-1:0] last_rsp_data;

  function automatic int pick(input logic r0, input logic r1, input int pref);
    if (r0 && r1) return pref;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  // One clock: inputs already applied; check outputs, advance model, move to next negedge.
  task automatic cycle();
    int w, r;
    rsp_t e;
    #1;
    last_rsp_vld  = rd_rsp_vld;
    last_rsp_id   = rd_rsp_id;
    last_rsp_data = rd_rsp_data;
    act_wr_gnt    = {wr_gnt[1], wr_gnt[0]};
    act_rd_gnt    = {rd_gnt[1], rd_gnt[0]};
    if (rsp_q.size() > 0) begin
      e = rsp_q.pop_front();
      check_eq("rsp_vld", rd_rsp_vld, 1);
      check_eq("rsp_id", rd_rsp_id, e.id);
      check_eq("rsp_data", rd_rsp_data, e.data);
    end else begin
      check_eq("rsp_vld_idle", rd_rsp_vld, 0);
    end
    for (int i = 0; i < 2; i++) begin exp_wr_gnt[i] = 0; exp_rd_gnt[i] = 0; end
    if (!rst_n) begin
      check_eq("rst_gnt", {act_wr_gnt, act_rd_gnt}, 0);
      check_eq("rst_we_re", {ram_we, ram_re}, 0);
      wr_pref = 0; rd_pref = 0; init_left = DEPTH;
      rsp_q.delete();
    end else if (init_left > 0) begin
      check_eq("init_we", ram_we, 1);
      check_eq("init_addr", ram_waddr, DEPTH - init_left);
      check_eq("init_data", ram_wdata, 0);
      check_eq("init_strb", ram_strb, {SW{1'b1}});
      check_eq("init_re", ram_re, 0);
      check_eq("init_gnt", {act_wr_gnt, act_rd_gnt}, 0);
      check_eq("init_done_lo", init_done, 0);
      ref_mem[DEPTH - init_left] = '0;
      init_left--;
    end else begin
      check_eq("init_done_hi", init_done, 1);
      w = pick(wr_req[0], wr_req[1], wr_pref);
      r = pick(rd_req[0], rd_req[1], rd_pref);
      check_eq("wr_gnt", act_wr_gnt, (w < 0) ? 2'b00 : (w == 0 ? 2'b01 : 2'b10));
      check_eq("rd_gnt", act_rd_gnt, (r < 0) ? 2'b00 : (r == 0 ? 2'b01 : 2'b10));
      check_eq("ram_we", ram_we, w >= 0);
      check_eq("ram_re", ram_re, r >= 0);
      if (w >= 0) begin
        check_eq("ram_waddr", ram_waddr, wr_addr[w]);
        check_eq("ram_wdata", ram_wdata, wr_data[w]);
        check_eq("ram_strb", ram_strb, wr_strb[w]);
        for (int b = 0; b < SW; b++)
          if (wr_strb[w][b]) ref_mem[wr_addr[w]][b*8 +: 8] = wr_data[w][b*8 +: 8];
        exp_wr_gnt[w] = 1;
        wr_pref = 1 - w;
      end
      if (r >= 0) begin
        check_eq("ram_raddr", ram_raddr, rd_addr[r]);
        e.id = bit'(r);
        e.data = ref_mem[rd_addr[r]];
        rsp_q.push_back(e);
        exp_rd_gnt[r] = 1;
        rd_pref = 1 - r;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic rand_reqs();
    int s;
    for (int i = 0; i < 2; i++) begin
      if (!rd_req[i] || exp_rd_gnt[i]) begin
        rd_req[i]  = ($urandom_range(3) != 0);
        rd_addr[i] = AW'($urandom_range(15));
      end
      if (!wr_req[i] || exp_wr_gnt[i]) begin
        wr_req[i]  = ($urandom_range(3) != 0);
        wr_addr[i] = AW'($urandom_range(15));
        wr_data[i] = rand_data();
        s = $urandom_range(3);
        wr_strb[i] = (s == 0) ? '0 : (s == 1) ? '1 : SW'($urandom());
      end
    end
  endtask

  task automatic idle_reqs();
    for (int i = 0; i < 2; i++) begin rd_req[i] = 0; wr_req[i] = 0; end
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) ram[a] = rand_data();
    for (int i = 0; i < 2; i++) begin
      rd_addr[i] = '0; wr_addr[i] = '0; wr_data[i] = '0; wr_strb[i] = '0;
    end
    wr_pref = 0; rd_pref = 0; init_left = DEPTH;
    // Requests held through reset and init must wait, then be served.
    rd_req[0] = 1; rd_addr[0] = 9'd5; rd_req[1] = 0;
    wr_req[0] = 0; wr_req[1] = 1; wr_addr[1] = 9'd2; wr_data[1] = rand_data(); wr_strb[1] = '1;
    rst_n = 0;
    @(negedge clk);
    repeat (3) cycle();
    rst_n = 1;
    repeat (DEPTH) cycle();
    cycle();  // first RUN cycle: both held requests granted
    check_eq("t1_held_gnt", {act_wr_gnt, act_rd_gnt}, 4'b1001);
    idle_reqs();
    cycle();
    check_eq("t1_rsp_data", last_rsp_data, 0);

    // Write then read back on the next cycle
    wr_req[0] = 1; wr_addr[0] = 9'd3; wr_data[0] = {SW{8'hAA}}; wr_strb[0] = '1;
    cycle();
    idle_reqs();
    rd_req[1] = 1; rd_addr[1] = 9'd3;
    cycle();
    idle_reqs();
    cycle();
    check_eq("t3_rsp_data", last_rsp_data, {SW{8'hAA}});
    check_eq("t3_rsp_id", last_rsp_id, 1);

    // Same-cycle partial write forwarded into the read of the same address
    wr_req[0] = 1; wr_addr[0] = 9'd7; wr_strb[0] = 32'h0000000F;
    wr_data[0] = {rand_data() | {DW{1'b1}}};
    wr_data[0][31:0] = 32'h11223344;
    rd_req[0] = 1; rd_addr[0] = 9'd7;
    cycle();
    idle_reqs();
    cycle();
    check_eq("t4_fwd_data", last_rsp_data, 256'h11223344);

    // Writer 1 alone three times, then both
    for (int k = 0; k < 3; k++) begin
      wr_req[1] = 1; wr_addr[1] = AW'(20 + k); wr_data[1] = rand_data(); wr_strb[1] = '1;
      cycle();
      check_eq("t5_solo_gnt", act_wr_gnt, 2'b10);
    end
    wr_req[0] = 1; wr_addr[0] = 9'd30; wr_data[0] = rand_data(); wr_strb[0] = '1;
    cycle();
    check_eq("t5_tie_gnt0", act_wr_gnt, 2'b01);
    wr_req[0] = 1; wr_addr[0] = 9'd31;
    cycle();
    check_eq("t5_tie_gnt1", act_wr_gnt, 2'b10);
    idle_reqs();
    cycle();

    // Both readers every cycle: alternating grants, continuous responses
    rd_req[0] = 1; rd_addr[0] = 9'd5; rd_req[1] = 1; rd_addr[1] = 9'd9;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (k > 0) check_eq("t2_vld_cont", last_rsp_vld, 1);
    end
    idle_reqs();
    cycle();

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      rand_reqs();
      cycle();
    end
    idle_reqs();
    cycle();

    // Reset in the middle of the sweep restarts it from zero
    rst_n = 0;
    cycle();
    rst_n = 1;
    repeat (100) cycle();
    rst_n = 0;
    cycle();
    rst_n = 1;
    repeat (DEPTH) cycle();

    // Reset while a read response is in flight
    rd_req[0] = 1; rd_addr[0] = 9'd3;
    cycle();
    idle_reqs();
    rst_n = 0;
    cycle();
    rst_n = 1;
    cycle();
    check_eq("t6_vld_drop", last_rsp_vld, 0);
    repeat (4) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
